// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_GAP_CYCLES     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  localparam int GRANT_W            = $clog2(DEF_N_REQ);

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above last_grant, else lowest.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic             valid,
  output logic [GW-1:0]    index
);

  logic [N_REQ-1:0] hi;
  logic [GW-1:0]    idx_hi, idx_lo;

  always_comb begin
    hi     = '0;
    idx_hi = '0;
    idx_lo = '0;
    for (int c = 0; c < N_REQ; c++)
      hi[c] = req[c] && (GW'(c) > last_grant);
    // descending scan leaves the lowest set bit in each candidate index
    for (int c = N_REQ - 1; c >= 0; c--) begin
      if (hi[c])  idx_hi = GW'(c);
      if (req[c]) idx_lo = GW'(c);
    end
    valid = |req;
    index = (|hi) ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ          = DEF_N_REQ,
  parameter  int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int GW             = idx_w(N_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   err,
  output logic               tx_send,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  arb_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             done_q, rise;
  logic [GW-1:0]    last_grant, last_d, grant_d;
  logic [7:0]       data_d;
  logic             send_d, busy_d;
  logic [N_REQ-1:0] ack_d, err_d, onehot;
  logic             pick_vld;
  logic [GW-1:0]    pick_idx;

  rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_pick (
    .req       (req),
    .last_grant(last_grant),
    .valid     (pick_vld),
    .index     (pick_idx)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    grant_d = grant_id;
    last_d  = last_grant;
    data_d  = tx_data;
    send_d  = 1'b0;
    ack_d   = '0;
    err_d   = '0;
    rise    = tx_done & ~done_q;
    onehot  = N_REQ'(1) << grant_id;
    case (state)
      IDLE: if (pick_vld) begin
        grant_d = pick_idx;
        data_d  = req_data[{pick_idx, 3'b000} +: 8];
        send_d  = 1'b1;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // a done edge wins over a coincident timeout
        if (rise || cnt == TO_LAST) begin
          ack_d   = onehot;
          err_d   = rise ? '0 : onehot;
          last_d  = grant_id;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      done_q     <= 1'b0;
      grant_id   <= '0;
      last_grant <= GW'(N_REQ - 1);
      tx_data    <= '0;
      tx_send    <= 1'b0;
      ack        <= '0;
      err        <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      done_q     <= tx_done;
      grant_id   <= grant_d;
      last_grant <= last_d;
      tx_data    <= data_d;
      tx_send    <= send_d;
      ack        <= ack_d;
      err        <= err_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench with a launch/ack scoreboard for uart_tx_arbiter.
module tb_uart_tx_arbiter;

  typedef struct { int id; logic [7:0] data; } launch_t;
  typedef struct { logic [3:0] ack; logic [3:0] err; } ackexp_t;

  logic        clock = 0;
  logic        reset = 0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack, err;
  logic        tx_send, tx_done = 0, busy;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  logic [3:0]  t_req = '0;
  logic [31:0] t_req_data = '0;
  logic [3:0]  t_ack, t_err;
  logic        t_tx_send, t_busy;
  logic        t_tx_done = 0;
  logic [7:0]  t_tx_data;
  logic [1:0]  t_grant_id;

  int n_tests = 0;
  int n_fail  = 0;
  launch_t launch_q[$];
  ackexp_t ack_q[$];

  always #5 clock = ~clock;

  uart_tx_arbiter u_dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .tx_send(tx_send), .tx_data(tx_data),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id)
  );

  uart_tx_arbiter #(.TIMEOUT_CYCLES(50)) u_dut_to (
    .clock(clock), .reset(reset), .req(t_req), .req_data(t_req_data),
    .ack(t_ack), .err(t_err), .tx_send(t_tx_send), .tx_data(t_tx_data),
    .tx_done(t_tx_done), .busy(t_busy), .grant_id(t_grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every launch and every ack pulse must match the next expectation
  always @(negedge clock) begin
    if (reset) begin
      if (tx_send) begin
        check("sb_send_expected", 32'(launch_q.size() != 0), 1);
        if (launch_q.size() != 0) begin
          launch_t e;
          e = launch_q.pop_front();
          check("sb_grant_id", 32'(grant_id), 32'(e.id));
          check("sb_tx_data", 32'(tx_data), 32'(e.data));
        end
      end
      if (ack != 0 || err != 0) begin
        check("sb_ack_expected", 32'(ack_q.size() != 0), 1);
        if (ack_q.size() != 0) begin
          ackexp_t a;
          a = ack_q.pop_front();
          check("sb_ack", 32'(ack), 32'(a.ack));
          check("sb_err", 32'(err), 32'(a.err));
        end
      end
    end
  end

  task automatic wait_send(input int limit, output bit found, output int n);
    found = 0; n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock); n++;
      if (tx_send) begin found = 1; break; end
    end
  endtask

  task automatic wait_ack(input int limit, output bit found, output int n);
    found = 0; n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock); n++;
      if (ack != 0) begin found = 1; break; end
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic run_frame(input string tag, input int done_delay);
    bit f; int n;
    wait_send(100, f, n);
    check({tag, "_send_seen"}, 32'(f), 1);
    repeat (done_delay) @(negedge clock);
    tx_done = 1;
    wait_ack(10, f, n);
    check({tag, "_ack_seen"}, 32'(f), 1);
    tx_done = 0;
  endtask

  initial begin
    bit f; int n; bit stable;

    // reset state
    reset = 0;
    repeat (2) @(negedge clock);
    check("rst_tx_send", 32'(tx_send), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    reset = 1;
    @(negedge clock);

    // single request, done 100 cycles after launch, then 16-cycle gap
    req_data[7:0] = 8'h55;
    req = 4'b0001;
    launch_q.push_back('{0, 8'h55});
    ack_q.push_back('{4'b0001, 4'b0000});
    wait_send(10, f, n);
    check("single_send_seen", 32'(f), 1);
    check("single_send_latency", 32'(n), 1);
    @(negedge clock);
    check("single_send_one_cycle", 32'(tx_send), 0);
    check("single_busy", 32'(busy), 1);
    repeat (99) @(negedge clock);
    tx_done = 1;
    wait_ack(10, f, n);
    check("single_ack_seen", 32'(f), 1);
    check("single_ack_latency", 32'(n), 1);
    req = 0; tx_done = 0;
    wait_idle(n);
    check("single_gap_len", 32'(n), 16);

    // round robin from a fresh reset: 0,1,2,3,0
    reset = 0;
    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      launch_q.push_back('{k % 4, 8'h10 + 8'(k % 4)});
      ack_q.push_back('{4'b0001 << (k % 4), 4'b0000});
    end
    for (int k = 0; k < 5; k++) run_frame("rr", 5);
    req = 0;
    wait_idle(n);

    // stale done level at launch is ignored
    tx_done = 1;
    req_data[15:8] = 8'h77;
    req = 4'b0010;
    launch_q.push_back('{1, 8'h77});
    ack_q.push_back('{4'b0010, 4'b0000});
    wait_send(100, f, n);
    check("stale_send_seen", 32'(f), 1);
    wait_ack(30, f, n);
    check("stale_no_ack_while_high", 32'(f), 0);
    tx_done = 0;
    repeat (3) @(negedge clock);
    tx_done = 1;
    wait_ack(5, f, n);
    check("stale_ack_after_edge", 32'(f), 1);
    tx_done = 0; req = 0;
    wait_idle(n);

    // reset mid-WAIT abandons the frame; requester 0 wins next
    req_data[31:24] = 8'h99;
    req_data[7:0]   = 8'h42;
    req = 4'b1000;
    launch_q.push_back('{3, 8'h99});
    wait_send(100, f, n);
    check("rstw_send_seen", 32'(f), 1);
    repeat (10) @(negedge clock);
    reset = 0;
    req = 4'b1001;
    @(negedge clock);
    check("rstw_busy", 32'(busy), 0);
    check("rstw_tx_send", 32'(tx_send), 0);
    check("rstw_tx_data", 32'(tx_data), 0);
    check("rstw_grant_id", 32'(grant_id), 0);
    check("rstw_ack", 32'(ack), 0);
    check("rstw_err", 32'(err), 0);
    reset = 1;
    launch_q.push_back('{0, 8'h42});
    ack_q.push_back('{4'b0001, 4'b0000});
    run_frame("rstw_next", 3);
    req = 0;
    wait_idle(n);

    // withdrawn request still completes and acks
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    launch_q.push_back('{2, 8'hA5});
    ack_q.push_back('{4'b0100, 4'b0000});
    wait_send(100, f, n);
    check("wd_send_seen", 32'(f), 1);
    repeat (5) @(negedge clock);
    req = 0;
    repeat (20) @(negedge clock);
    tx_done = 1;
    wait_ack(10, f, n);
    check("wd_ack_seen", 32'(f), 1);
    tx_done = 0;
    wait_idle(n);

    // timeout on the 50-cycle instance: ack+err after 50 WAIT cycles
    t_req_data[7:0] = 8'h3C;
    t_req = 4'b0001;
    f = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (t_tx_send) begin f = 1; break; end
    end
    check("to_send_seen", 32'(f), 1);
    f = 0; n = 0; stable = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); n++;
      if (t_ack != 0) begin f = 1; break; end
      if (t_tx_data !== 8'h3C) stable = 0;
    end
    check("to_ack_seen", 32'(f), 1);
    check("to_ack_latency", 32'(n), 51);
    check("to_ack", 32'(t_ack), 32'h1);
    check("to_err", 32'(t_err), 32'h1);
    check("to_data_stable", 32'(stable), 1);
    t_req = 0;
    @(negedge clock);
    check("to_ack_one_cycle", 32'(t_ack), 0);
    check("to_err_one_cycle", 32'(t_err), 0);
    check("to_gap_busy", 32'(t_busy), 1);
    n = 1;
    while (t_busy === 1'b1 && n < 200) begin n++; @(negedge clock); end
    check("to_gap_len", 32'(n), 16);

    check("sb_launch_drained", 32'(launch_q.size()), 0);
    check("sb_ack_drained", 32'(ack_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
